vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Upstream stage of the pixel renderer: generates the raster scan that feeds the renderer's `clk`, `valid`, `x`, `y` inputs. It also drives the VGA connector's hsync/vsync.
- Divides the board clock into a pixel-clock enable and runs horizontal/vertical counters over a 640x480@60 frame.
- Emits line-start and frame-start strobes, which the character/scroll logic uses instead of free-running timer bits.
- Sync outputs are delayed so they stay aligned with the renderer's registered RGB latency.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, active level of hsync/vsync (0 = active-low)
- CLK_DIV, 2, clk cycles per pixel (>=1)
- PIPE_DLY, 2, pixel ticks by which hsync/vsync lag x/y/valid (0..7)

Ports:
- clk  in  1  board clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  scan enable; low = scan parked
- pix_ce  out  1  one-clk pulse per pixel tick
- valid  out  1  high when (x,y) is inside the active area
- x  out  10  current horizontal count (raw, includes blanking)
- y  out  10  current vertical count (raw, includes blanking)
- hsync  out  1  horizontal sync, polarity SYNC_POL, delayed PIPE_DLY ticks
- vsync  out  1  vertical sync, polarity SYNC_POL, delayed PIPE_DLY ticks
- line_start  out  1  pulse (width 1 pix_ce) when x==0
- frame_start  out  1  pulse (width 1 pix_ce) when x==0 && y==0
- frame_cnt  out  16  frames completed since reset, wraps at 65535->0

Behaviour:
- Derived constants: H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525).
- Reset (rst_n low, async), values held until the first clk edge after release:
  - divider = 0, h_cnt = 0, v_cnt = 0, frame_cnt = 0
  - pix_ce = 0, valid = 0, x = 0, y = 0, line_start = 0, frame_start = 0
  - hsync = vsync = ~SYNC_POL (inactive); the whole delay line is filled with the inactive level
- Divider:
  - counts 0..CLK_DIV-1; pix_ce = 1 on the clk where divider == CLK_DIV-1.
  - CLK_DIV = 1: pix_ce is constantly 1 after reset.
  - The divider runs regardless of en.
- Counters advance only on pix_ce with en = 1:
  - h_cnt increments and wraps H_TOTAL-1 -> 0.
  - On that wrap v_cnt increments and wraps V_TOTAL-1 -> 0.
  - When v_cnt wraps, frame_cnt increments.
- Outputs are registered and update on the same clk edge as the counters (x == h_cnt, y == v_cnt; no extra latency). Between pix_ce pulses they hold their values.
- valid = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- Raw sync is active when:
  - horizontal: H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751)
  - vertical: V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491)
- Sync delay:
  - raw hsync/vsync pass through a PIPE_DLY-deep shift register clocked on pix_ce.
  - PIPE_DLY = 0: the raw registered value is output directly.
- line_start / frame_start:
  - asserted for the single pix_ce period in which the registered x == 0 (and y == 0 for frame_start); low otherwise.
- en low:
  - on the next pix_ce, h_cnt, v_cnt, x and y go to 0, valid = 0, and both raw syncs go inactive.
  - strobes stay low while en = 0.
  - frame_cnt holds.
- en rising:
  - the first pix_ce with en = 1 presents x = 0, y = 0, valid = 1, line_start = 1, frame_start = 1.
  - x = 1 follows on the next tick.
- Wrap boundary: the wrap tick from (799,524) to (0,0) raises frame_start and frame_cnt+1 in the same update.
- frame_cnt does not increment at en rising; it counts only completed V_TOTAL wraps.
- Reset asserted mid-frame: immediate async return to reset values; no partial sync pulse persists.

Decomposition:
- Shared package `vga_pkg`:
  - the 640x480@60 timing constants (used here and by the renderer's blanking logic)
  - sync polarity constants
  - 10-bit coordinate typedef
- One natural sub-module, `sync_delay`: a parameterised pix_ce-enabled shift register for the PIPE_DLY alignment, instantiated once for {hsync, vsync}.

Test Plan:
- Release rst_n, en=1, CLK_DIV=2 -> pix_ce every 2nd clk; first tick x=0, y=0, valid=1, frame_start=1; hsync=vsync=1 throughout reset.
- Run one full line -> valid falls at x=640; raw hsync low for x=656..751 (96 ticks), seen on the pin 2 ticks later; line_start at x=0 of the next line with y=1.
- Run one full frame -> vsync low exactly for y=490..491 (1600 ticks); at wrap (799,524)->(0,0): frame_start=1, frame_cnt 0->1.
- Deassert en at x=300, y=100 -> next tick x=0, y=0, valid=0, strobes 0, frame_cnt unchanged; re-assert -> first tick frame_start=1.
- Assert rst_n low mid-hsync (x=700) -> hsync immediately 1, x=y=0, frame_cnt=0 without waiting for clk.
- CLK_DIV=1, PIPE_DLY=0 -> pix_ce constantly high; hsync low on the same cycle x becomes 656.

Source files
------------

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared 640x480@60 timing constants, sync polarity and coordinate types
package vga_pkg;

  // 640x480@60 raster, also used by the renderer's blanking logic
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int COORD_W = 10;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic {
    SYNC_ACTIVE_LOW  = 1'b0,
    SYNC_ACTIVE_HIGH = 1'b1
  } sync_pol_e;

  // Scan is parked after reset or while en is low; the first enabled tick restarts at (0,0)
  typedef enum logic {
    SCAN_PARKED = 1'b0,
    SCAN_RUN    = 1'b1
  } scan_state_e;

  // Half-open window test lo <= c < hi
  function automatic logic in_window(coord_t c, coord_t lo, coord_t hi);
    return (c >= lo) && (c < hi);
  endfunction

endpackage

// File: rtl/sync_delay.sv
// rtl/sync_delay.sv - pix_ce-enabled shift register aligning syncs with the RGB pipeline
module sync_delay #(
  parameter int               WIDTH     = 2,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_ce,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  generate
    if (DEPTH == 0) begin : g_bypass
      logic w_unused;
      assign w_unused = ^{i_clk, i_rst_n, i_ce};
      assign o_data   = i_data;
    end else begin : g_shift
      logic [WIDTH-1:0] r_sr [DEPTH];

      // Shift one stage per pixel tick; reset fills every stage with the inactive level
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          for (int i = 0; i < DEPTH; i++) r_sr[i] <= RESET_VAL;
        end else if (i_ce) begin
          r_sr[0] <= i_data;
          for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
        end
      end

      assign o_data = r_sr[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - pixel-clock divider, raster counters, strobes and aligned syncs
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = VGA_H_ACTIVE,
  parameter int   H_FP     = VGA_H_FP,
  parameter int   H_SYNC   = VGA_H_SYNC,
  parameter int   H_BP     = VGA_H_BP,
  parameter int   V_ACTIVE = VGA_V_ACTIVE,
  parameter int   V_FP     = VGA_V_FP,
  parameter int   V_SYNC   = VGA_V_SYNC,
  parameter int   V_BP     = VGA_V_BP,
  parameter logic SYNC_POL = SYNC_ACTIVE_LOW,
  parameter int   CLK_DIV  = 2,
  parameter int   PIPE_DLY = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_en,
  output logic        o_pix_ce,
  output logic        o_valid,
  output coord_t      o_x,
  output coord_t      o_y,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_line_start,
  output logic        o_frame_start,
  output logic [15:0] o_frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
  localparam coord_t H_ACT_C  = coord_t'(H_ACTIVE);
  localparam coord_t V_ACT_C  = coord_t'(V_ACTIVE);
  localparam coord_t HS_START = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t HS_END   = coord_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam coord_t VS_START = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t VS_END   = coord_t'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic SYNC_OFF = ~SYNC_POL;

  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] w_div_next;
  logic             r_pix_ce;

  scan_state_e r_state;
  scan_state_e w_state_next;

  coord_t      r_h_cnt;
  coord_t      r_v_cnt;
  coord_t      w_h_next;
  coord_t      w_v_next;
  logic        w_frame_wrap;

  logic        r_valid;
  logic        r_line_start;
  logic        r_frame_start;
  logic        r_hsync_raw;
  logic        r_vsync_raw;
  logic [15:0] r_frame_cnt;
  logic [1:0]  w_sync_dly;

  assign w_div_next = (r_div == DIV_LAST) ? '0 : r_div + 1'b1;

  // Free-running divider; pix_ce is registered so it stays low through reset even when CLK_DIV is 1
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div    <= '0;
      r_pix_ce <= 1'b0;
    end else begin
      r_div    <= w_div_next;
      r_pix_ce <= (w_div_next == DIV_LAST);
    end
  end

  // Scan state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= SCAN_PARKED;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next scan state and counter values; a parked scan restarts at (0,0) rather than advancing
  always_comb begin
    w_state_next = r_state;
    w_h_next     = r_h_cnt;
    w_v_next     = r_v_cnt;
    w_frame_wrap = 1'b0;
    if (r_pix_ce) begin
      if (!i_en) begin
        w_state_next = SCAN_PARKED;
        w_h_next     = '0;
        w_v_next     = '0;
      end else if (r_state == SCAN_PARKED) begin
        w_state_next = SCAN_RUN;
        w_h_next     = '0;
        w_v_next     = '0;
      end else if (r_h_cnt == H_LAST) begin
        w_h_next = '0;
        if (r_v_cnt == V_LAST) begin
          w_v_next     = '0;
          w_frame_wrap = 1'b1;
        end else begin
          w_v_next = r_v_cnt + 1'b1;
        end
      end else begin
        w_h_next = r_h_cnt + 1'b1;
      end
    end
  end

  // Counters and registered outputs all update together on the pixel tick
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_h_cnt       <= '0;
      r_v_cnt       <= '0;
      r_valid       <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_hsync_raw   <= SYNC_OFF;
      r_vsync_raw   <= SYNC_OFF;
      r_frame_cnt   <= '0;
    end else if (r_pix_ce) begin
      r_h_cnt       <= w_h_next;
      r_v_cnt       <= w_v_next;
      r_valid       <= i_en && (w_h_next < H_ACT_C) && (w_v_next < V_ACT_C);
      r_line_start  <= i_en && (w_h_next == '0);
      r_frame_start <= i_en && (w_h_next == '0) && (w_v_next == '0);
      r_hsync_raw   <= (i_en && in_window(w_h_next, HS_START, HS_END)) ? SYNC_POL : SYNC_OFF;
      r_vsync_raw   <= (i_en && in_window(w_v_next, VS_START, VS_END)) ? SYNC_POL : SYNC_OFF;
      if (w_frame_wrap) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

  sync_delay #(
    .WIDTH     (2),
    .DEPTH     (PIPE_DLY),
    .RESET_VAL ({SYNC_OFF, SYNC_OFF})
  ) u_sync_delay (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_ce    (r_pix_ce),
    .i_data  ({r_hsync_raw, r_vsync_raw}),
    .o_data  (w_sync_dly)
  );

  assign o_pix_ce      = r_pix_ce;
  assign o_valid       = r_valid;
  assign o_x           = r_h_cnt;
  assign o_y           = r_v_cnt;
  assign o_hsync       = w_sync_dly[1];
  assign o_vsync       = w_sync_dly[0];
  assign o_line_start  = r_line_start;
  assign o_frame_start = r_frame_start;
  assign o_frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen against a frame-position model
module tb_vga_timing_gen;

  localparam int NI = 3;
  localparam int HA  [NI] = '{16, 10, 640};
  localparam int HF  [NI] = '{2, 3, 16};
  localparam int HS  [NI] = '{4, 5, 96};
  localparam int HB  [NI] = '{3, 2, 48};
  localparam int VA  [NI] = '{8, 6, 480};
  localparam int VF  [NI] = '{2, 1, 10};
  localparam int VS  [NI] = '{2, 3, 2};
  localparam int VB  [NI] = '{3, 2, 33};
  localparam int DIV [NI] = '{2, 1, 2};
  localparam int DLY [NI] = '{2, 0, 2};
  localparam bit POL [NI] = '{1'b0, 1'b1, 1'b0};

  typedef struct {
    int n;
    int x;
    int y;
    int fcnt;
    bit valid;
    bit ls;
    bit fs;
    bit hs;
    bit vs;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;

  logic        ce  [NI];
  logic        val [NI];
  logic [9:0]  xo  [NI];
  logic [9:0]  yo  [NI];
  logic        hs  [NI];
  logic        vs  [NI];
  logic        ls  [NI];
  logic        fs  [NI];
  logic [15:0] fc  [NI];

  exp_t sb [NI][$];
  int   pos [NI];
  int   fcnt_m [NI];
  int   hist [NI][8];
  int   ncyc = 0;
  int   mcyc = 0;
  int   errors = 0;
  int   checks = 0;

  vga_timing_gen #(
    .H_ACTIVE(HA[0]), .H_FP(HF[0]), .H_SYNC(HS[0]), .H_BP(HB[0]),
    .V_ACTIVE(VA[0]), .V_FP(VF[0]), .V_SYNC(VS[0]), .V_BP(VB[0]),
    .SYNC_POL(POL[0]), .CLK_DIV(DIV[0]), .PIPE_DLY(DLY[0])
  ) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .o_pix_ce(ce[0]), .o_valid(val[0]),
    .o_x(xo[0]), .o_y(yo[0]), .o_hsync(hs[0]), .o_vsync(vs[0]),
    .o_line_start(ls[0]), .o_frame_start(fs[0]), .o_frame_cnt(fc[0])
  );

  vga_timing_gen #(
    .H_ACTIVE(HA[1]), .H_FP(HF[1]), .H_SYNC(HS[1]), .H_BP(HB[1]),
    .V_ACTIVE(VA[1]), .V_FP(VF[1]), .V_SYNC(VS[1]), .V_BP(VB[1]),
    .SYNC_POL(POL[1]), .CLK_DIV(DIV[1]), .PIPE_DLY(DLY[1])
  ) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .o_pix_ce(ce[1]), .o_valid(val[1]),
    .o_x(xo[1]), .o_y(yo[1]), .o_hsync(hs[1]), .o_vsync(vs[1]),
    .o_line_start(ls[1]), .o_frame_start(fs[1]), .o_frame_cnt(fc[1])
  );

  vga_timing_gen #(
    .H_ACTIVE(HA[2]), .H_FP(HF[2]), .H_SYNC(HS[2]), .H_BP(HB[2]),
    .V_ACTIVE(VA[2]), .V_FP(VF[2]), .V_SYNC(VS[2]), .V_BP(VB[2]),
    .SYNC_POL(POL[2]), .CLK_DIV(DIV[2]), .PIPE_DLY(DLY[2])
  ) u_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .o_pix_ce(ce[2]), .o_valid(val[2]),
    .o_x(xo[2]), .o_y(yo[2]), .o_hsync(hs[2]), .o_vsync(vs[2]),
    .o_line_start(ls[2]), .o_frame_start(fs[2]), .o_frame_cnt(fc[2])
  );

  initial forever #5 clk = ~clk;

  // Clock edges since reset release, used to check pixel tick spacing
  always @(posedge clk) begin
    if (!rst_n) mcyc = 0;
    else mcyc = mcyc + 1;
  end

  task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s inst%0d: got %0d expected %0d at %0t", name, inst, act, want, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      pos[i] = -1;
      fcnt_m[i] = 0;
      for (int k = 0; k < 8; k++) hist[i][k] = -1;
      sb[i].delete();
    end
  endtask

  // Reference: the scan is a single position in the frame (-1 when parked), syncs look back DLY ticks
  task automatic predict(input int i, input int n);
    exp_t e;
    int ht, vt, p, px, py;
    ht = HA[i] + HF[i] + HS[i] + HB[i];
    vt = VA[i] + VF[i] + VS[i] + VB[i];
    if (!en) pos[i] = -1;
    else if (pos[i] < 0) pos[i] = 0;
    else begin
      pos[i]++;
      if (pos[i] == ht * vt) begin
        pos[i] = 0;
        fcnt_m[i] = (fcnt_m[i] + 1) % 65536;
      end
    end
    for (int k = 7; k > 0; k--) hist[i][k] = hist[i][k-1];
    hist[i][0] = pos[i];
    e.n = n;
    e.fcnt = fcnt_m[i];
    if (pos[i] < 0) begin
      e.x = 0; e.y = 0; e.valid = 0; e.ls = 0; e.fs = 0;
    end else begin
      e.x = pos[i] % ht;
      e.y = pos[i] / ht;
      e.valid = (e.x < HA[i]) && (e.y < VA[i]);
      e.ls = (e.x == 0);
      e.fs = (pos[i] == 0);
    end
    p = hist[i][DLY[i]];
    px = (p < 0) ? -1 : p % ht;
    py = (p < 0) ? -1 : p / ht;
    e.hs = (px >= HA[i] + HF[i] && px < HA[i] + HF[i] + HS[i]) ? POL[i] : !POL[i];
    e.vs = (py >= VA[i] + VF[i] && py < VA[i] + VF[i] + VS[i]) ? POL[i] : !POL[i];
    sb[i].push_back(e);
  endtask

  // Drive en for the next clock edge, queue expectations for instances that tick on it
  task automatic step(input bit new_en);
    int n;
    en = new_en;
    n = ncyc + 1;
    for (int i = 0; i < NI; i++)
      if ((n % DIV[i]) == 0 && n >= 2) predict(i, n);
    @(posedge clk);
    ncyc = n;
    @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    for (int i = 0; i < NI; i++) begin
      chk({tag, "_pix_ce"}, i, ce[i], 0);
      chk({tag, "_valid"}, i, val[i], 0);
      chk({tag, "_x"}, i, xo[i], 0);
      chk({tag, "_y"}, i, yo[i], 0);
      chk({tag, "_line_start"}, i, ls[i], 0);
      chk({tag, "_frame_start"}, i, fs[i], 0);
      chk({tag, "_hsync"}, i, hs[i], !POL[i]);
      chk({tag, "_vsync"}, i, vs[i], !POL[i]);
      chk({tag, "_frame_cnt"}, i, fc[i], 0);
    end
  endtask

  task automatic monitor();
    bit [NI-1:0] seen;
    exp_t e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) seen[i] = rst_n && ce[i];
      if (seen != '0) begin
        @(posedge clk);
        #1;
        if (rst_n) begin
          for (int i = 0; i < NI; i++) begin
            if (seen[i]) begin
              if (sb[i].size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_tick inst%0d: got pix_ce at edge %0d expected none at %0t", i, mcyc, $time);
              end else begin
                e = sb[i].pop_front();
                chk("tick_edge", i, mcyc, e.n);
                chk("x", i, xo[i], e.x);
                chk("y", i, yo[i], e.y);
                chk("valid", i, val[i], e.valid);
                chk("line_start", i, ls[i], e.ls);
                chk("frame_start", i, fs[i], e.fs);
                chk("hsync", i, hs[i], e.hs);
                chk("vsync", i, vs[i], e.vs);
                chk("frame_cnt", i, fc[i], e.fcnt);
              end
            end
          end
        end
      end
    end
  endtask

  initial begin
    bit cur_en;
    int k;
    model_reset();
    fork
      monitor();
    join_none

    rst_n = 1'b0;
    en = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset("por");
    rst_n = 1'b1;
    ncyc = 0;

    repeat (1700) step(1'b1);

    k = 0;
    while (pos[0] != 5 * 25 + 10 && k < 3000) begin
      step(1'b1);
      k++;
    end
    chk("reach_en_drop_point", 0, pos[0], 5 * 25 + 10);
    repeat (7) step(1'b0);
    repeat (800) step(1'b1);

    cur_en = 1'b1;
    repeat (3000) begin
      if ($urandom_range(39, 0) == 0) cur_en = ~cur_en;
      step(cur_en);
    end

    k = 0;
    while (pos[0] != 3 * 25 + 21 && k < 3000) begin
      step(1'b1);
      k++;
    end
    chk("reach_mid_hsync", 0, pos[0], 3 * 25 + 21);
    chk("pre_reset_hsync_active", 0, hs[0], POL[0]);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset("async");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    ncyc = 0;
    repeat (600) step(1'b1);

    for (int i = 0; i < NI; i++) chk("leftover_expect", i, sb[i].size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
